// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared types and constants for the cache memory arbiter
//
// Holds the arbiter state encoding and the default widths and timeouts that
// the interface and the arbiter take their parameter defaults from.
package cache_mem_arbiter_pkg;

    // Data-cache line width; the memory port moves one whole line per transaction.
    localparam int DCACHE_LINE_W = 128;

    // Default watchdog limit for a granted memory transaction.
    localparam int ARB_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2,
        RESP    = 2'd3
    } type_arb_state_e;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache-side and memory-side signal bundle of the arbiter
//
// Ports of the bundle:
//   dcache_req_i/wr_i/addr_i/wdata_i, dcache_ack_o/rdata_o : data-cache line fills and writebacks
//   icache_req_i/addr_i, icache_ack_o/rdata_o              : instruction-cache line fills
//   bus_err_o                                              : timeout flag qualified by an ack pulse
//   mem_req_o/wr_o/addr_o/wdata_o, mem_ack_i/rdata_i       : single main-memory port
// Modports:
//   master : arbiter view (drives acks and the memory request)
//   slave  : environment view (caches and memory)
interface cache_mem_arbiter_if
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = DCACHE_LINE_W
) ();

    logic              dcache_req_i;
    logic              dcache_wr_i;
    logic [ADDR_W-1:0] dcache_addr_i;
    logic [LINE_W-1:0] dcache_wdata_i;
    logic              dcache_ack_o;
    logic [LINE_W-1:0] dcache_rdata_o;

    logic              icache_req_i;
    logic [ADDR_W-1:0] icache_addr_i;
    logic              icache_ack_o;
    logic [LINE_W-1:0] icache_rdata_o;

    logic              bus_err_o;

    logic              mem_req_o;
    logic              mem_wr_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_rdata_i;

    modport master (
        input  dcache_req_i, dcache_wr_i, dcache_addr_i, dcache_wdata_i,
        output dcache_ack_o, dcache_rdata_o,
        input  icache_req_i, icache_addr_i,
        output icache_ack_o, icache_rdata_o,
        output bus_err_o,
        output mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        output dcache_req_i, dcache_wr_i, dcache_addr_i, dcache_wdata_i,
        input  dcache_ack_o, dcache_rdata_o,
        output icache_req_i, icache_addr_i,
        input  icache_ack_o, icache_rdata_o,
        input  bus_err_o,
        input  mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin sharing of the main-memory port between dcache and icache
//
// Ports:
//   clk_i : the only clock
//   rst_i : synchronous active-high reset
//   bus   : cache request/ack pairs and the memory port (cache_mem_arbiter_if.master)
// One whole-line transaction is granted at a time. A grant lasts until memory
// acks or the watchdog expires; the result is returned to the granted cache as
// a one-cycle registered ack, with bus_err_o marking a timed-out transaction.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int LINE_W         = DCACHE_LINE_W,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input  logic                clk_i,
    input  logic                rst_i,
    cache_mem_arbiter_if.master bus
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  TERM  = CNT_W'(TIMEOUT_CYCLES - 1);

    type_arb_state_e  state;
    logic             last_d;
    logic [CNT_W-1:0] cnt;
    logic             pick_d;
    logic             done;

    // dcache wins when alone, or on a tie when icache was served last.
    assign pick_d = bus.dcache_req_i && (!bus.icache_req_i || !last_d);

    // An ack on the terminal count still completes normally.
    assign done = bus.mem_ack_i || (cnt == TERM);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state              <= IDLE;
            last_d             <= 1'b0;
            cnt                <= '0;
            bus.mem_req_o      <= 1'b0;
            bus.mem_wr_o       <= 1'b0;
            bus.mem_addr_o     <= {ADDR_W{1'b0}};
            bus.mem_wdata_o    <= {LINE_W{1'b0}};
            bus.dcache_ack_o   <= 1'b0;
            bus.dcache_rdata_o <= {LINE_W{1'b0}};
            bus.icache_ack_o   <= 1'b0;
            bus.icache_rdata_o <= {LINE_W{1'b0}};
            bus.bus_err_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dcache_req_i || bus.icache_req_i) begin
                        if (pick_d) begin
                            state           <= GRANT_D;
                            bus.mem_wr_o    <= bus.dcache_wr_i;
                            bus.mem_addr_o  <= bus.dcache_addr_i;
                            bus.mem_wdata_o <= bus.dcache_wdata_i;
                            last_d          <= 1'b1;
                        end else begin
                            state           <= GRANT_I;
                            bus.mem_wr_o    <= 1'b0;
                            bus.mem_addr_o  <= bus.icache_addr_i;
                            bus.mem_wdata_o <= {LINE_W{1'b0}};
                            last_d          <= 1'b0;
                        end
                        cnt           <= '0;
                        bus.mem_req_o <= 1'b1;
                    end
                end

                GRANT_D, GRANT_I: begin
                    // Saturating watchdog; the grant ends on TERM so it never wraps.
                    if (cnt != TERM) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (done) begin
                        state         <= RESP;
                        bus.mem_req_o <= 1'b0;
                        bus.bus_err_o <= !bus.mem_ack_i;
                        if (state == GRANT_D) begin
                            bus.dcache_ack_o   <= 1'b1;
                            bus.dcache_rdata_o <= bus.mem_ack_i ? bus.mem_rdata_i : {LINE_W{1'b0}};
                        end else begin
                            bus.icache_ack_o   <= 1'b1;
                            bus.icache_rdata_o <= bus.mem_ack_i ? bus.mem_rdata_i : {LINE_W{1'b0}};
                        end
                    end
                end

                RESP: begin
                    state              <= IDLE;
                    bus.dcache_ack_o   <= 1'b0;
                    bus.icache_ack_o   <= 1'b0;
                    bus.bus_err_o      <= 1'b0;
                    bus.dcache_rdata_o <= {LINE_W{1'b0}};
                    bus.icache_rdata_o <= {LINE_W{1'b0}};
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int T  = 8;
    localparam logic [LW-1:0] DEADBEEF = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(T)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } req_t;

    req_t d_q[$];
    req_t i_q[$];

    // ---------------- requesters: hold until ack, drop, stay low one cycle ----
    bit d_active, i_active;
    int d_gap, i_gap;
    int d_req_cyc, i_req_cyc;

    always @(negedge clk) begin
        req_t r;
        if (rst) begin
            bus.dcache_req_i   = 1'b0;
            bus.dcache_wr_i    = 1'b0;
            bus.dcache_addr_i  = '0;
            bus.dcache_wdata_i = '0;
            bus.icache_req_i   = 1'b0;
            bus.icache_addr_i  = '0;
            d_active = 0; i_active = 0; d_gap = 0; i_gap = 0;
        end else begin
            if (d_active) begin
                if (bus.dcache_ack_o === 1'b1) begin
                    bus.dcache_req_i = 1'b0; d_active = 0; d_gap = 1;
                end
            end else if (d_gap > 0) begin
                d_gap--;
            end else if (d_q.size() > 0) begin
                r = d_q.pop_front();
                bus.dcache_req_i   = 1'b1;
                bus.dcache_wr_i    = r.wr;
                bus.dcache_addr_i  = r.addr;
                bus.dcache_wdata_i = r.wdata;
                d_active = 1; d_req_cyc = cyc;
            end
            if (i_active) begin
                if (bus.icache_ack_o === 1'b1) begin
                    bus.icache_req_i = 1'b0; i_active = 0; i_gap = 1;
                end
            end else if (i_gap > 0) begin
                i_gap--;
            end else if (i_q.size() > 0) begin
                r = i_q.pop_front();
                bus.icache_req_i  = 1'b1;
                bus.icache_addr_i = r.addr;
                i_active = 1; i_req_cyc = cyc;
            end
        end
    end

    // ---------------- memory: ack mem_delay cycles after req rises (-1 = never)
    int            mem_delay = 0;
    logic [LW-1:0] mem_data  = DEADBEEF;
    int            rise_cyc;
    bit            in_req;

    always @(negedge clk) begin
        if (rst || bus.mem_req_o !== 1'b1) begin
            in_req = 0;
            bus.mem_ack_i   = 1'b0;
            bus.mem_rdata_i = ~mem_data;
        end else begin
            if (!in_req) begin
                in_req = 1; rise_cyc = cyc;
            end
            if (mem_delay >= 0 && cyc - rise_cyc == mem_delay) begin
                bus.mem_ack_i = 1'b1; bus.mem_rdata_i = mem_data;
            end else begin
                bus.mem_ack_i = 1'b0; bus.mem_rdata_i = ~mem_data;
            end
        end
    end

    // ---------------- transaction-level model: cycle numbers of grant and response
    bit            m_ready, m_valid, m_side_d, m_wr, m_err, m_last_d;
    int            m_g, m_r;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, m_data;

    always @(posedge clk) begin
        bit dq, iq;
        if (rst) begin
            m_ready = 1; m_valid = 0; m_last_d = 0;
        end else if (m_ready) begin
            if (!m_valid || (m_r >= 0 && cyc > m_r)) begin
                m_valid = 0;
                dq = (bus.dcache_req_i === 1'b1);
                iq = (bus.icache_req_i === 1'b1);
                if (dq || iq) begin
                    m_side_d = (dq && iq) ? !m_last_d : dq;
                    if (m_side_d) begin
                        m_wr = bus.dcache_wr_i; m_addr = bus.dcache_addr_i; m_wdata = bus.dcache_wdata_i;
                    end else begin
                        m_wr = 0; m_addr = bus.icache_addr_i; m_wdata = '0;
                    end
                    m_last_d = m_side_d;
                    m_valid  = 1;
                    m_g = cyc + 1;
                    m_r = -1;
                end
            end else if (m_r < 0) begin
                if (bus.mem_ack_i === 1'b1) begin
                    m_r = cyc + 1; m_err = 0; m_data = bus.mem_rdata_i;
                end else if (cyc - m_g == T - 1) begin
                    m_r = cyc + 1; m_err = 1; m_data = '0;
                end
            end
        end
        cyc++;
    end

    // ---------------- per-cycle compare and ack logging ----------------------
    bit            ack_log[$];
    int            d_ack_count, i_ack_count, d_ack_cyc, i_ack_cyc;
    logic [LW-1:0] d_ack_data, i_ack_data;
    logic          d_ack_err, i_ack_err;
    bit            saw_wr;

    always @(negedge clk) begin
        bit busy, ackc;
        if (m_ready) begin
            busy = m_valid && cyc >= m_g && (m_r < 0 || cyc < m_r);
            ackc = m_valid && cyc == m_r;
            chk("mem_req", LW'(bus.mem_req_o), LW'(busy));
            if (busy) begin
                chk("mem_wr",    LW'(bus.mem_wr_o),   LW'(m_wr));
                chk("mem_addr",  LW'(bus.mem_addr_o), LW'(m_addr));
                chk("mem_wdata", bus.mem_wdata_o,     m_wdata);
            end
            chk("dcache_ack", LW'(bus.dcache_ack_o), LW'(ackc && m_side_d));
            chk("icache_ack", LW'(bus.icache_ack_o), LW'(ackc && !m_side_d));
            chk("bus_err",    LW'(bus.bus_err_o),    LW'(ackc && m_err));
            if (ackc && m_side_d)  chk("dcache_rdata", bus.dcache_rdata_o, m_data);
            if (ackc && !m_side_d) chk("icache_rdata", bus.icache_rdata_o, m_data);
        end
        if (bus.mem_wr_o === 1'b1) saw_wr = 1;
        if (bus.dcache_ack_o === 1'b1) begin
            ack_log.push_back(1'b1);
            d_ack_count++; d_ack_cyc = cyc; d_ack_data = bus.dcache_rdata_o; d_ack_err = bus.bus_err_o;
        end
        if (bus.icache_ack_o === 1'b1) begin
            ack_log.push_back(1'b0);
            i_ack_count++; i_ack_cyc = cyc; i_ack_data = bus.icache_rdata_o; i_ack_err = bus.bus_err_o;
        end
    end

    // ---------------- helpers ------------------------------------------------
    task automatic wait_quiet(input int budget, input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (d_q.size() == 0 && i_q.size() == 0 && !d_active && !i_active &&
                d_gap == 0 && i_gap == 0 && bus.mem_req_o !== 1'b1 &&
                bus.dcache_ack_o !== 1'b1 && bus.icache_ack_o !== 1'b1)
                quiet++;
            else
                quiet = 0;
        end
        if (quiet < 3) begin
            checks++; errors++;
            $display("FAIL %s: wait budget of %0d cycles expired", name, budget);
        end
    endtask

    task automatic push_d(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
        req_t r;
        r.wr = wr; r.addr = addr; r.wdata = wdata;
        d_q.push_back(r);
    endtask

    task automatic push_i(input logic [AW-1:0] addr);
        req_t r;
        r.wr = 0; r.addr = addr; r.wdata = '0;
        i_q.push_back(r);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_mem_req"},   LW'(bus.mem_req_o),   '0);
        chk({name, "_mem_wr"},    LW'(bus.mem_wr_o),    '0);
        chk({name, "_mem_addr"},  LW'(bus.mem_addr_o),  '0);
        chk({name, "_mem_wdata"}, bus.mem_wdata_o,      '0);
        chk({name, "_acks_err"},  LW'({bus.dcache_ack_o, bus.icache_ack_o, bus.bus_err_o}), '0);
        chk({name, "_rdata"},     bus.dcache_rdata_o | bus.icache_rdata_o, '0);
    endtask

    // ---------------- directed scenarios -------------------------------------
    initial begin
        int same;
        int n;
        int cnt_before;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Single dcache fill, memory acks 3 cycles after mem_req rises.
        mem_delay = 3; mem_data = DEADBEEF; saw_wr = 0; d_ack_count = 0;
        push_d(1'b0, 32'h8000_0040, '0);
        wait_quiet(100, "fill_wait");
        chk("fill_ack_count", LW'(d_ack_count), LW'(1));
        chk("fill_rdata",     d_ack_data, DEADBEEF);
        chk("fill_err",       LW'(d_ack_err), '0);
        chk("fill_wr_low",    LW'(saw_wr), '0);
        chk("fill_latency",   LW'(d_ack_cyc - d_req_cyc), LW'(5));

        // Simultaneous requests right after reset: dcache first.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mem_delay = 1; mem_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        ack_log.delete();
        push_d(1'b1, 32'h100, 128'hCAFE_F00D_0000_0000_0000_0000_0000_0001);
        push_i(32'h200);
        wait_quiet(100, "tie1_wait");
        chk("tie1_count",  LW'(ack_log.size()), LW'(2));
        chk("tie1_first",  LW'(ack_log.size() > 0 ? ack_log[0] : 1'bx), LW'(1));
        chk("tie1_second", LW'(ack_log.size() > 1 ? ack_log[1] : 1'bx), LW'(0));

        // dcache served alone, then a tie must go to icache.
        ack_log.delete();
        push_d(1'b0, 32'h140, '0);
        wait_quiet(100, "solo_wait");
        push_d(1'b1, 32'h180, 128'h5);
        push_i(32'h240);
        wait_quiet(100, "tie2_wait");
        chk("tie2_count", LW'(ack_log.size()), LW'(3));
        chk("tie2_first", LW'(ack_log.size() > 1 ? ack_log[1] : 1'bx), LW'(0));
        chk("tie2_then",  LW'(ack_log.size() > 2 ? ack_log[2] : 1'bx), LW'(1));

        // Continuous contention: 10 transactions must alternate.
        mem_delay = 0;
        ack_log.delete();
        for (int k = 0; k < 5; k++) begin
            push_d(k[0], 32'h1000 + 32'(k * 16), 128'(k + 100));
            push_i(32'h2000 + 32'(k * 16));
        end
        wait_quiet(400, "contend_wait");
        chk("contend_count", LW'(ack_log.size()), LW'(10));
        same = 0;
        n = ack_log.size();
        for (int k = 1; k < n; k++) if (ack_log[k] == ack_log[k-1]) same++;
        chk("contend_alternate", LW'(same), '0);

        // Timeout: memory never acks an icache fill.
        mem_delay = -1; i_ack_count = 0;
        push_i(32'h300);
        wait_quiet(100, "timeout_wait");
        chk("timeout_count",   LW'(i_ack_count), LW'(1));
        chk("timeout_latency", LW'(i_ack_cyc - i_req_cyc), LW'(9));
        chk("timeout_err",     LW'(i_ack_err), LW'(1));
        chk("timeout_rdata",   i_ack_data, '0);

        // Ack on the terminal count: real data, no error.
        mem_delay = T - 1; mem_data = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
        push_i(32'h340);
        wait_quiet(100, "term_wait");
        chk("term_latency", LW'(i_ack_cyc - i_req_cyc), LW'(9));
        chk("term_err",     LW'(i_ack_err), '0);
        chk("term_rdata",   i_ack_data, 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0);

        // Reset while the dcache grant is waiting on memory.
        mem_delay = -1;
        cnt_before = d_ack_count;
        push_d(1'b1, 32'h400, 128'hBEEF);
        n = 0;
        while (bus.mem_req_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL midgrant_req: mem_req never rose");
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midgrant");
        @(negedge clk);
        rst = 1'b0;
        chk("midgrant_no_ack", LW'(d_ack_count), LW'(cnt_before));
        mem_delay = 0;
        ack_log.delete();
        push_d(1'b0, 32'h500, '0);
        push_i(32'h600);
        wait_quiet(100, "post_reset_wait");
        chk("post_reset_tie", LW'(ack_log.size() > 0 ? ack_log[0] : 1'bx), LW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single main-memory port between the write-back data cache (line fills and dirty-line writebacks) and the instruction cache (line fills). It sits between the two cache controllers and the memory interface, and grants one whole-line transaction at a time with round-robin fairness. Each transaction is held until memory acknowledges it or a watchdog timeout expires. Responses are registered and returned to the winning cache as a one-cycle ack pulse.

## Interface
- `ADDR_W`, default 32: physical address width.
- `LINE_W`, default 128: cache line width; equals the data-cache line width constant.
- `TIMEOUT_CYCLES`, default 256: maximum cycles a granted transaction waits for `mem_ack_i`; must be ≥ 2.
- `clk_i` in, 1: the only clock.
- `rst_i` in, 1: reset, synchronous and active-high.
- `dcache_req_i` in, 1: dcache transaction request; held until `dcache_ack_o`.
- `dcache_wr_i` in, 1: 1 = writeback, 0 = line fill.
- `dcache_addr_i` in, `ADDR_W`: line address.
- `dcache_wdata_i` in, `LINE_W`: writeback data.
- `dcache_ack_o` out, 1: one-cycle completion pulse.
- `dcache_rdata_o` out, `LINE_W`: fill data; valid while `dcache_ack_o` is high.
- `icache_req_i` in, 1: icache fill request; held until `icache_ack_o`.
- `icache_addr_i` in, `ADDR_W`: line address.
- `icache_ack_o` out, 1: one-cycle completion pulse.
- `icache_rdata_o` out, `LINE_W`: fill data; valid while `icache_ack_o` is high.
- `bus_err_o` out, 1: high together with the ack pulse when the transaction timed out.
- `mem_req_o` out, 1: memory request.
- `mem_wr_o` out, 1: memory write enable.
- `mem_addr_o` out, `ADDR_W`: memory address.
- `mem_wdata_o` out, `LINE_W`: memory write data.
- `mem_ack_i` in, 1: memory completion; sampled only while `mem_req_o` = 1.
- `mem_rdata_i` in, `LINE_W`: read data; valid with `mem_ack_i`.

## Operation
- **States:** IDLE, GRANT_D, GRANT_I, RESP.
- **IDLE, arbitration:**
  - Only dcache requesting → GRANT_D.
  - Only icache requesting → GRANT_I.
  - Both requesting → the requester not served last wins (round-robin).
  - `last_d` flag records the last winner; it resets to 0, so dcache wins the first tie after reset.
- **On entering GRANT_x:**
  - Capture the winner's address, write enable and write data into `mem_*_o` registers. For icache, `mem_wr_o` = 0 and `mem_wdata_o` = 0.
  - Update `last_d`.
  - Clear the watchdog counter.
  - Hold `mem_req_o` = 1 for the whole grant.
  - Requester inputs are ignored after capture; changing them mid-grant has no effect.
- **GRANT_x, completing:**
  - On `mem_ack_i` = 1: capture `mem_rdata_i`, go to RESP, drop `mem_req_o`.
  - If the counter reaches `TIMEOUT_CYCLES`−1 with no ack: go to RESP with the error flag set and read data = 0.
  - Ack and timeout in the same cycle: the ack wins and no error is reported.
- **RESP:**
  - Exactly one of `dcache_ack_o` / `icache_ack_o` is 1 (the granted side); `bus_err_o` equals the error flag.
  - Next state is always IDLE.
  - Requesters must drop `req` in the cycle after they see ack. IDLE therefore samples fresh requests, and a held request is re-arbitrated as a new transaction.
- **Reset:**
  - Any state → IDLE.
  - All outputs are 0, including `mem_*_o` and `*_rdata_o`.
  - `last_d` = 0 and the counter = 0.
  - Reset during GRANT abandons the memory transaction with no ack to either cache.
- **Width rule:** the watchdog counter is `$clog2(TIMEOUT_CYCLES)` bits wide and never wraps; it saturates at the terminal count.

## Timing
- Request seen in IDLE at cycle N → `mem_req_o` = 1 and `mem_addr_o` valid from N+1.
- `mem_ack_i` at cycle M ≥ N+1:
  - cache ack and rdata at M+1;
  - `mem_req_o` low from M+1;
  - IDLE at M+2.
- Minimum request-to-ack latency is 2 cycles (memory acks at N+1, cache ack at N+2).
- Back-to-back throughput: one transaction per 3 cycles minimum (IDLE, GRANT, RESP).
- Timeout with no ack from N+1: `bus_err_o` and ack at N+1+`TIMEOUT_CYCLES`.
- Requests arriving during GRANT or RESP wait; they are arbitrated in the next IDLE.

## Structure
- `type_arb_state_e` (IDLE, GRANT_D, GRANT_I, RESP) goes in `cache_defs.svh`.
- The default `ARB_TIMEOUT_CYCLES` constant also goes in `cache_defs.svh`.
- `LINE_W` defaults from the existing dcache line-width constant.
- Single module, no sub-modules; the two-way round-robin is one flag and does not justify a separate arbiter module.

## Test plan
- **Single dcache fill:**
  - Stimulus: addr 0x8000_0040; memory acks 3 cycles after `mem_req_o` rises with data 0xDEAD…BEEF.
  - Required: `dcache_ack_o` is one pulse carrying that data, and `mem_wr_o` = 0 throughout.
- **Simultaneous requests after reset:**
  - Stimulus: dcache writeback to 0x100 and icache fill to 0x200 in the same cycle; both hold their requests.
  - Required: dcache is granted first, then icache. A second tie grants icache first.
- **Continuous contention:**
  - Stimulus: both requesters re-assert immediately after each ack, for 10 transactions.
  - Required: grants alternate D, I, D, I…, with no two consecutive grants to the same side.
- **Timeout:**
  - Stimulus: `TIMEOUT_CYCLES` = 8 and memory never acks an icache fill.
  - Required: `icache_ack_o` and `bus_err_o` pulse together exactly 9 cycles after the request cycle, with rdata = 0.
- **Ack on the terminal count:**
  - Required: the ack pulses with real data and `bus_err_o` = 0.
- **Reset mid-grant:**
  - Stimulus: assert `rst_i` while in GRANT_D.
  - Required: next cycle all outputs = 0 and the state is IDLE. A following tie grants dcache.
